// File: rtl/ws2812b_frame_scheduler.sv
// ws2812b_frame_scheduler
// ----------------------------------------------------------------------------
// Frame-level sequencer in front of the ws2812b bit-serialiser.
// The host fills a small {G,R,B} pixel buffer one byte at a time. On a host
// start pulse or on an internal refresh tick, pixels 0..len-1 are handed to
// the serialiser over a valid/ready handshake. The serialiser takes a pixel
// by pulling ready low while valid is high. led_latch marks the last pixel
// of the frame.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset (clears the buffer too)
//   wr_en        host byte write strobe
//   wr_addr      {pixel index, byte select}; 0=G 1=R 2=B 3=ignored
//   wr_data      write byte
//   start        one-frame request pulse
//   auto_en      enables the periodic refresh timer
//   num_leds     active pixel count (0 = nothing, clamps to NUM_PIXELS)
//   led_ready    serialiser ready
//   led_data     pixel {G,R,B} to the serialiser
//   led_valid    pixel valid
//   led_latch    end-of-frame latch request, qualified by led_valid
//   busy         high whenever the sequencer is not idle
//   frame_done   one-cycle pulse after the last pixel has been accepted
//   frame_count  completed frames, wraps 255 -> 0
// ----------------------------------------------------------------------------
module ws2812b_frame_scheduler #(
  parameter int NUM_PIXELS     = 16,
  parameter int REFRESH_PERIOD = 1066667
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_PIXELS)+1:0]   wr_addr,
  input  logic [7:0]                      wr_data,
  input  logic                            start,
  input  logic                            auto_en,
  input  logic [$clog2(NUM_PIXELS):0]     num_leds,
  input  logic                            led_ready,
  output logic [23:0]                     led_data,
  output logic                            led_valid,
  output logic                            led_latch,
  output logic                            busy,
  output logic                            frame_done,
  output logic [7:0]                      frame_count
);

  localparam int IW = $clog2(NUM_PIXELS);
  localparam int LW = IW + 1;
  localparam int CW = $clog2(REFRESH_PERIOD + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(NUM_PIXELS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_RDY = 3'd2,
    SEND     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   len_q, len_d;
  logic            pending_q, pending_d;
  logic [23:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            latch_q, latch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      count_q, count_d;
  logic [CW-1:0]   cnt_q;
  logic [23:0]     mem_q [NUM_PIXELS];

  logic            tick_s;
  logic            req_s;
  logic [LW-1:0]   len_s;
  logic            last_s;
  logic [IW-1:0]   wr_pix_s;

  assign wr_pix_s = wr_addr[IW+1:2];
  assign tick_s   = auto_en && (cnt_q == CNT_LAST);
  // A start and a tick in the same cycle are a single request.
  assign req_s    = start | tick_s;
  assign len_s    = (num_leds > MAX_LEN) ? MAX_LEN : num_leds;
  assign last_s   = ({1'b0, idx_q} == (len_q - LW'(1)));

  // Pixel buffer: byte-wise host writes, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        mem_q[i] <= 24'h000000;
      end
    end else if (wr_en) begin
      case (wr_addr[1:0])
        2'd0:    mem_q[wr_pix_s][23:16] <= wr_data;
        2'd1:    mem_q[wr_pix_s][15:8]  <= wr_data;
        2'd2:    mem_q[wr_pix_s][7:0]   <= wr_data;
        default: ;
      endcase
    end
  end

  // Refresh timer: free-runs while auto_en is set, held at zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!auto_en) begin
      cnt_q <= '0;
    end else if (tick_s) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      pending_q <= 1'b0;
      data_q    <= 24'h000000;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    pending_d = pending_q | req_s;
    data_d    = data_q;
    valid_d   = valid_q;
    latch_d   = latch_q;
    done_d    = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        if (pending_q | req_s) begin
          // The request is consumed here whether or not a frame is sent.
          pending_d = 1'b0;
          if (len_s != LW'(0)) begin
            state_d = LOAD;
            idx_d   = '0;
            len_d   = len_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        // Reads the buffer contents from before any write this same cycle.
        data_d  = mem_q[idx_q];
        latch_d = 1'b0;
        state_d = WAIT_RDY;
      end

      WAIT_RDY: begin
        if (led_ready) begin
          valid_d = 1'b1;
          // Latch is raised together with valid so it never leads the pixel.
          latch_d = last_s;
          state_d = SEND;
        end else begin
          state_d = WAIT_RDY;
        end
      end

      SEND: begin
        // ready falling while valid is held is the acceptance of the pixel.
        if (!led_ready) begin
          valid_d = 1'b0;
          latch_d = 1'b0;
          if (last_s) begin
            state_d = DONE;
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = LOAD;
          end
        end else begin
          state_d = SEND;
        end
      end

      DONE: begin
        if (pending_q && (len_s != LW'(0))) begin
          // Back-to-back frame; a request arriving right now stays queued.
          state_d   = LOAD;
          idx_d     = '0;
          len_d     = len_s;
          pending_d = req_s;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        latch_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign led_data    = data_q;
  assign led_valid   = valid_q;
  assign led_latch   = latch_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Scoreboard bench for ws2812b_frame_scheduler: stimulus pushes the expected
// pixels and frame counts; a monitor pops and compares on every new pixel
// (rising led_valid) and on every frame_done pulse.
module tb_ws2812b_frame_scheduler;

  localparam int NP = 16;
  localparam int RP = 100;

  typedef struct packed {
    logic [23:0] data;
    logic        latch;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic        auto_en;
  logic [4:0]  num_leds;
  logic        led_ready;
  logic [23:0] led_data;
  logic        led_valid;
  logic        led_latch;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;

  pix_t        exp_pix_q[$];
  int          exp_cnt_q[$];
  int          done_cyc[$];
  logic [23:0] model_mem [NP];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rises = 0;
  int dones = 0;
  int last_rise_cyc = 0;
  int start_cyc = 0;
  int exp_fc = 0;
  int drop_dly = 1;
  int low_len = 1;
  bit busy_seen = 1'b0;

  ws2812b_frame_scheduler #(.NUM_PIXELS(NP), .REFRESH_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .auto_en(auto_en),
    .num_leds(num_leds), .led_ready(led_ready), .led_data(led_data),
    .led_valid(led_valid), .led_latch(led_latch), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Bench cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sampled 2 ns after each rising edge.
  initial begin : monitor
    logic prev_valid;
    logic [23:0] held;
    pix_t e;
    prev_valid = 1'b0;
    held = 24'h0;
    forever begin
      @(posedge clk);
      #2;
      if (busy) busy_seen = 1'b1;
      if (led_valid && !prev_valid) begin
        rises++;
        last_rise_cyc = cyc;
        check("ready_at_valid", {31'd0, led_ready}, 32'd1);
        if (exp_pix_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pixel: got 0x%06h expected none", led_data);
        end else begin
          e = exp_pix_q.pop_front();
          check("pixel_data", {8'd0, led_data}, {8'd0, e.data});
          check("pixel_latch", {31'd0, led_latch}, {31'd0, e.latch});
        end
        held = led_data;
      end else if (led_valid) begin
        check("data_stable", {8'd0, led_data}, {8'd0, held});
      end
      if (frame_done) begin
        dones++;
        done_cyc.push_back(cyc);
        if (exp_cnt_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame_done: got count %0d expected none", frame_count);
        end else begin
          check("frame_count", {24'd0, frame_count}, exp_cnt_q.pop_front());
        end
      end
      prev_valid = led_valid;
    end
  end

  // Serialiser model: drops ready drop_dly cycles after seeing a pixel,
  // holds it low for low_len cycles, then raises it again.
  initial begin : serialiser
    led_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (led_valid && led_ready) begin
        repeat (drop_dly) @(negedge clk);
        led_ready = 1'b0;
        repeat (low_len) @(negedge clk);
        led_ready = 1'b1;
      end
    end
  end

  task automatic wr(input int pix, input int sel, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 6'(pix * 4 + sel);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    case (sel)
      0: model_mem[pix][23:16] = d;
      1: model_mem[pix][15:8] = d;
      2: model_mem[pix][7:0] = d;
      default: ;
    endcase
  endtask

  task automatic wr_pix(input int pix, input logic [23:0] v);
    wr(pix, 0, v[23:16]);
    wr(pix, 1, v[15:8]);
    wr(pix, 2, v[7:0]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_frame(input int n);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.data = model_mem[i];
      p.latch = (i == n - 1);
      exp_pix_q.push_back(p);
    end
    exp_fc = (exp_fc + 1) & 255;
    exp_cnt_q.push_back(exp_fc);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_pix_q.size() == 0 && exp_cnt_q.size() == 0) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pixels/%0d frames outstanding expected 0",
               name, exp_pix_q.size(), exp_cnt_q.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int i;
    for (int k = 0; k < NP; k++) model_mem[k] = 24'h0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'd0;
    start = 1'b0; auto_en = 1'b0; num_leds = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, led_valid}, 32'd0);
    check("rst_latch", {31'd0, led_latch}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_count", {24'd0, frame_count}, 32'd0);
    check("rst_data", {8'd0, led_data}, 32'd0);
    reset = 1'b0;

    // Single pixel, latency and latch.
    drop_dly = 2; low_len = 1;
    wr_pix(0, 24'h112233);
    num_leds = 5'd1;
    expect_frame(1);
    pulse_start();
    wait_idle(200, "single");
    check("start_latency", 32'(last_rise_cyc - start_cyc), 32'd3);
    check("single_count", {24'd0, frame_count}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd0);

    // Four pixels, serialiser slow to come back ready.
    wr_pix(0, 24'h010203);
    wr_pix(1, 24'h040506);
    wr_pix(2, 24'h070809);
    wr_pix(3, 24'h0A0B0C);
    num_leds = 5'd4;
    low_len = 30;
    expect_frame(4);
    pulse_start();
    wait_idle(1000, "four");

    // Three requests during a frame collapse into one extra frame.
    expect_frame(4);
    expect_frame(4);
    pulse_start();
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      repeat (10) @(negedge clk);
    end
    wait_idle(2000, "collapse");
    repeat (50) @(negedge clk);
    check("collapse_busy", {31'd0, busy}, 32'd0);
    check("collapse_count", {24'd0, frame_count}, 32'd4);

    // Zero length: request discarded and not left pending.
    low_len = 1; drop_dly = 1;
    num_leds = 5'd0;
    busy_seen = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
    num_leds = 5'd1;
    repeat (20) @(negedge clk);
    check("zero_len_busy", {31'd0, busy_seen}, 32'd0);
    check("zero_len_count", {24'd0, frame_count}, 32'd4);

    // Length clamp; byte select 3 is ignored.
    wr(5, 0, 8'h5A);
    wr(5, 3, 8'hFF);
    num_leds = 5'd20;
    expect_frame(NP);
    pulse_start();
    wait_idle(1000, "clamp");
    check("clamp_count", {24'd0, frame_count}, 32'd5);

    // Auto refresh every RP cycles, stopped by auto_en.
    num_leds = 5'd2;
    expect_frame(2);
    expect_frame(2);
    expect_frame(2);
    base = dones;
    auto_en = 1'b1;
    for (i = 0; i < 500 && dones < base + 3; i++) @(negedge clk);
    auto_en = 1'b0;
    check("auto_frames", 32'(dones - base), 32'd3);
    if (dones >= base + 3) begin
      check("auto_period1", 32'(done_cyc[base + 1] - done_cyc[base]), 32'(RP));
      check("auto_period2", 32'(done_cyc[base + 2] - done_cyc[base + 1]), 32'(RP));
    end
    repeat (250) @(negedge clk);
    check("auto_stop_count", {24'd0, frame_count}, 32'd8);

    // Reset in the middle of pixel 2.
    drop_dly = 2; low_len = 1;
    num_leds = 5'd4;
    expect_frame(4);
    base = rises;
    pulse_start();
    for (i = 0; i < 300 && rises < base + 3; i++) begin
      @(posedge clk);
      #3;
    end
    check("reach_pixel2", 32'(rises - base), 32'd3);
    reset = 1'b1;
    exp_pix_q.delete();
    exp_cnt_q.delete();
    exp_fc = 0;
    for (int k = 0; k < NP; k++) model_mem[k] = 24'h0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", {31'd0, led_valid}, 32'd0);
    check("mid_rst_latch", {31'd0, led_latch}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_count", {24'd0, frame_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    num_leds = 5'd1;
    expect_frame(1);
    pulse_start();
    wait_idle(200, "post_reset");
    check("post_reset_count", {24'd0, frame_count}, 32'd1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
